// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cache-line memory port between icache and dcache.
// Serialises block transactions and aborts hung ones after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 64,
  parameter int PRIO_D  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  localparam bit PD = (PRIO_D != 0);

  typedef enum logic [1:0] {
    IDLE, BUSY_I, BUSY_D, RESP
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last_d, last_d_n;
  logic pick_d, done;
  logic en_n, wr_n, iack_n, dack_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] mdata_n, idata_n, ddata_n;
  logic [1:0] grant_n;

  // ties go to dcache under PD, else to whoever did not win last
  assign pick_d = d_req_i && (!i_req_i || PD || !last_d);
  assign done = mem_ack_i || (cnt == TLIM);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_d_n = last_d;
    en_n     = mem_enable_o;
    wr_n     = mem_write_o;
    addr_n   = mem_addr_o;
    mdata_n  = mem_data_o;
    idata_n  = i_data_o;
    ddata_n  = d_data_o;
    iack_n   = 1'b0;
    dack_n   = 1'b0;
    grant_n  = grant_o;
    err_n    = err_o;
    unique case (state)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          state_n  = pick_d ? BUSY_D : BUSY_I;
          cnt_n    = '0;
          last_d_n = pick_d;
          en_n     = 1'b1;
          wr_n     = pick_d && d_write_i;
          addr_n   = pick_d ? d_addr_i : i_addr_i;
          mdata_n  = pick_d ? d_data_i : '0;
          grant_n  = pick_d ? 2'b10 : 2'b01;
        end
      end
      BUSY_I, BUSY_D: begin
        cnt_n = cnt + 1'b1;
        if (done) begin
          state_n = RESP;
          en_n    = 1'b0;
          grant_n = 2'b00;
          iack_n  = (state == BUSY_I);
          dack_n  = (state == BUSY_D);
          if (!mem_ack_i) err_n = 1'b1;
          if (state == BUSY_I) begin
            idata_n = mem_ack_i ? mem_data_i : '0;
          end else if (!mem_ack_i) begin
            ddata_n = '0;
          end else if (!mem_write_o) begin
            ddata_n = mem_data_i;
          end
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      last_d       <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      i_data_o     <= '0;
      d_data_o     <= '0;
      i_ack_o      <= 1'b0;
      d_ack_o      <= 1'b0;
      grant_o      <= 2'b00;
      err_o        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last_d       <= last_d_n;
      mem_enable_o <= en_n;
      mem_write_o  <= wr_n;
      mem_addr_o   <= addr_n;
      mem_data_o   <= mdata_n;
      i_data_o     <= idata_n;
      d_data_o     <= ddata_n;
      i_ack_o      <= iack_n;
      d_ack_o      <= dack_n;
      grant_o      <= grant_n;
      err_o        <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus ack scoreboard for mem_arbiter,
// with a second round-robin instance for the tie-break rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data;
  logic i_ack;
  logic d_req = 1'b0;
  logic d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_data;
  logic d_ack;
  logic m_en, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;
  logic [1:0] grant;
  logic err;

  logic r_i_req = 1'b0;
  logic r_d_req = 1'b0;
  logic [AW-1:0] r_i_addr = '0;
  logic [AW-1:0] r_d_addr = '0;
  logic [DW-1:0] r_i_data, r_d_data;
  logic r_i_ack, r_d_ack;
  logic r_en, r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic r_ack = 1'b0;
  logic [1:0] r_grant;
  logic r_err;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 32'hA5A5A5E5}};
  endfunction

  assign m_rdata = pat(m_addr);
  assign r_rdata = pat(r_addr);

  mem_arbiter #(.TIMEOUT(64), .PRIO_D(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_data_o(i_data), .i_ack_o(i_ack),
    .d_req_i(d_req), .d_write_i(d_write),
    .d_addr_i(d_addr), .d_data_i(d_wdata),
    .d_data_o(d_data), .d_ack_o(d_ack),
    .mem_enable_o(m_en), .mem_write_o(m_wr),
    .mem_addr_o(m_addr), .mem_data_o(m_wdata),
    .mem_data_i(m_rdata),
    .mem_ack_i(auto_ack | man_ack),
    .grant_o(grant), .err_o(err)
  );

  mem_arbiter #(.TIMEOUT(64), .PRIO_D(0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(r_i_req), .i_addr_i(r_i_addr),
    .i_data_o(r_i_data), .i_ack_o(r_i_ack),
    .d_req_i(r_d_req), .d_write_i(1'b0),
    .d_addr_i(r_d_addr), .d_data_i('0),
    .d_data_o(r_d_data), .d_ack_o(r_d_ack),
    .mem_enable_o(r_en), .mem_write_o(r_wr),
    .mem_addr_o(r_addr), .mem_data_o(r_wdata),
    .mem_data_i(r_rdata), .mem_ack_i(r_ack),
    .grant_o(r_grant), .err_o(r_err)
  );

  // memory model: acks mem_delay cycles after enable rises (-1 = never)
  int mem_delay = -1;
  int mcnt = 0;
  int en_len = 0;
  always @(posedge clk) begin
    #1;
    if (m_en) begin
      mcnt = mcnt + 1;
      auto_ack = (mem_delay > 0) && (mcnt == mem_delay);
    end else begin
      if (mcnt != 0) en_len = mcnt;
      mcnt = 0;
      auto_ack = 1'b0;
    end
  end

  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    if (r_en) begin
      rcnt = rcnt + 1;
      r_ack = (rcnt == 2);
    end else begin
      rcnt = 0;
      r_ack = 1'b0;
    end
  end

  typedef struct {
    int who;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    bit is_d;
    bit wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int dly;
    logic [DW-1:0] exp_data;
  } vec_t;

  exp_t q[$];
  exp_t rq[$];
  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic bad(input string name);
    total++;
    $display("FAIL %s", name);
  endtask

  task automatic sb(input bit rr, input int who, input logic [DW-1:0] data);
    exp_t e;
    if (rr ? (rq.size() == 0) : (q.size() == 0)) begin
      bad($sformatf("unexpected_ack rr=%0d who=%0d", rr, who));
      return;
    end
    if (rr) e = rq.pop_front();
    else e = q.pop_front();
    chk(rr ? "rr_ack_who" : "ack_who", DW'(who), DW'(e.who));
    chk(rr ? "rr_ack_data" : "ack_data", data, e.data);
  endtask

  // one cycle; requesters drop their request on seeing their ack
  task automatic tick();
    @(negedge clk);
    if (i_ack) begin i_req = 1'b0; sb(1'b0, 1, i_data); end
    if (d_ack) begin d_req = 1'b0; sb(1'b0, 2, d_data); end
    if (r_i_ack) begin r_i_req = 1'b0; sb(1'b1, 1, r_i_data); end
    if (r_d_ack) begin r_d_req = 1'b0; sb(1'b1, 2, r_d_data); end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(i_ack || d_ack) && n < 200);
    if (!(i_ack || d_ack)) bad("wait_ack_budget");
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    mem_delay = v.dly;
    if (v.is_d) begin
      d_req = 1'b1; d_write = v.wr;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    q.push_back('{v.is_d ? 2 : 1, v.exp_data});
    tick();
    chk("grant", DW'(grant), DW'(v.is_d ? 2'b10 : 2'b01));
    chk("mem_en", DW'(m_en), DW'(1'b1));
    chk("mem_wr", DW'(m_wr), DW'(v.wr));
    chk("mem_addr", DW'(m_addr), DW'(v.addr));
    chk("mem_wdata", m_wdata, v.is_d ? v.wdata : '0);
    wait_ack(n);
    chk("ack_latency", DW'(n), DW'(v.dly));
    chk("resp_grant", DW'(grant), '0);
    tick();
    chk("ack_pulse", DW'(i_ack | d_ack), '0);
    chk("en_len", DW'(en_len), DW'(v.dly));
  endtask

  task automatic rr_go(input bit ir, input bit dr,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da);
    int k;
    if (ir) begin r_i_req = 1'b1; r_i_addr = ia; end
    if (dr) begin r_d_req = 1'b1; r_d_addr = da; end
    k = 0;
    while ((r_i_req || r_d_req) && k < 100) begin
      tick();
      k++;
    end
    if (r_i_req || r_d_req) bad("rr_budget");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  vec_t vt[5];
  int n;

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h40, '0, 10, pat(32'h40)};
    vt[1] = '{1'b1, 1'b1, 32'h400, {8{32'h12345678}}, 3, '0};
    vt[2] = '{1'b1, 1'b0, 32'h800, {8{32'h0BADF00D}}, 1, pat(32'h800)};
    vt[3] = '{1'b1, 1'b1, 32'h840, {8{32'hDEADBEEF}}, 2, pat(32'h800)};
    vt[4] = '{1'b0, 1'b0, 32'h80, '0, 4, pat(32'h80)};

    tick();
    tick();
    chk("rst_ctl", DW'({i_ack, d_ack, m_en, m_wr, grant, err}), '0);
    chk("rst_i_data", i_data, '0);
    chk("rst_d_data", d_data, '0);
    chk("rst_mem_addr", DW'(m_addr), '0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // simultaneous requests: dcache first, icache two cycles after d_ack
    mem_delay = 2;
    d_write = 1'b0; d_addr = 32'h900; i_addr = 32'hC0;
    d_req = 1'b1; i_req = 1'b1;
    q.push_back('{2, pat(32'h900)});
    q.push_back('{1, pat(32'hC0)});
    tick();
    chk("tie_grant_d", DW'(grant), DW'(2'b10));
    wait_ack(n);
    chk("tie_d_ack", DW'(d_ack), DW'(1'b1));
    tick();
    chk("tie_gap", DW'(grant), '0);
    tick();
    chk("tie_grant_i", DW'(grant), DW'(2'b01));
    wait_ack(n);
    tick();

    // memory never answers
    mem_delay = -1;
    d_write = 1'b0; d_addr = 32'hA00; d_req = 1'b1;
    q.push_back('{2, '0});
    tick();
    chk("to_grant", DW'(grant), DW'(2'b10));
    chk("to_err_pre", DW'(err), '0);
    wait_ack(n);
    chk("to_cycles", DW'(n), DW'(64));
    chk("to_err", DW'(err), DW'(1'b1));
    chk("to_en", DW'(m_en), '0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    chk("late_ctl", DW'({m_en, grant, i_ack, d_ack}), '0);
    chk("late_err", DW'(err), DW'(1'b1));
    chk("late_d_data", d_data, '0);

    // spurious ack while idle
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    chk("spur_ctl", DW'({m_en, grant, i_ack, d_ack}), '0);
    chk("spur_i_data", i_data, pat(32'hC0));
    chk("spur_d_data", d_data, '0);
    chk("spur_err", DW'(err), DW'(1'b1));

    // reset in the middle of a dcache write
    d_write = 1'b1; d_addr = 32'hB00;
    d_wdata = {8{32'hCAFEF00D}}; d_req = 1'b1;
    tick();
    chk("mid_grant", DW'(grant), DW'(2'b10));
    tick();
    tick();
    #2 rst = 1'b0;
    d_req = 1'b0;
    #1;
    chk("mid_rst_ctl", DW'({i_ack, d_ack, m_en, m_wr, grant, err}), '0);
    chk("mid_rst_i_data", i_data, '0);
    chk("mid_rst_d_data", d_data, '0);
    chk("mid_rst_addr", DW'(m_addr), '0);
    chk("mid_rst_wdata", m_wdata, '0);
    tick();
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_grant", DW'(grant), '0);
    run_vec('{1'b0, 1'b0, 32'h140, '0, 2, pat(32'h140)});

    // round-robin instance
    rq.push_back('{1, pat(32'h1000)});
    rr_go(1'b1, 1'b0, 32'h1000, 32'h0);
    rq.push_back('{2, pat(32'h2040)});
    rq.push_back('{1, pat(32'h1040)});
    rr_go(1'b1, 1'b1, 32'h1040, 32'h2040);
    rq.push_back('{2, pat(32'h2080)});
    rr_go(1'b0, 1'b1, 32'h0, 32'h2080);
    rq.push_back('{1, pat(32'h10C0)});
    rq.push_back('{2, pat(32'h20C0)});
    rr_go(1'b1, 1'b1, 32'h10C0, 32'h20C0);
    chk("rr_err", DW'(r_err), '0);

    chk("sb_empty", DW'(q.size() + rq.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
